// File: rtl/fdd_track_cache_ctrl.sv
// Floppy track cache controller: streams whole tracks of 512-byte blocks between
// the drive's track buffer and the SD block port, writing dirty tracks back first.
module fdd_track_cache_ctrl #(
  parameter int SECTORS    = 13,
  parameter int TRACK_BITS = 6
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [TRACK_BITS-1:0] track,
  input  logic                  disk_we,
  input  logic                  img_mounted,
  input  logic                  img_readonly,
  input  logic                  img_size_nz,
  input  logic                  sd_ack,
  output logic [31:0]           sd_lba,
  output logic                  sd_rd,
  output logic                  sd_wr,
  output logic [3:0]            track_sec,
  output logic                  cpu_wait,
  output logic                  dirty
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER} state_t;

  localparam logic [31:0] SEC32    = 32'(SECTORS);
  localparam logic [3:0]  LAST_SEC = 4'(SECTORS - 1);

  state_t                state, state_next;
  logic                  old_ack, ack_rise, ack_fall;
  logic                  mounted, protect, reload_pend;
  logic [TRACK_BITS-1:0] cur_track, tgt;
  logic [31:0]           lba_base;
  logic                  start_wr, start_rd, sec_next, wr_done, rd_done;

  function automatic logic [31:0] lba_of(input logic [TRACK_BITS-1:0] t);
    return 32'(t) * SEC32;
  endfunction

  assign ack_rise = sd_ack & ~old_ack;
  assign ack_fall = ~sd_ack & old_ack;
  assign sd_lba   = lba_base + {28'd0, track_sec};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_wr   = 1'b0;
    start_rd   = 1'b0;
    sec_next   = 1'b0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    sd_rd      = 1'b0;
    sd_wr      = 1'b0;
    cpu_wait   = (state != IDLE);
    case (state)
      IDLE: begin
        if (mounted && ((track != cur_track) || reload_pend)) begin
          if (dirty && !protect && !reload_pend) begin
            state_next = WR_REQ;
            start_wr   = 1'b1;
          end else begin
            state_next = RD_REQ;
            start_rd   = 1'b1;
          end
        end
      end
      WR_REQ: begin
        sd_wr = 1'b1;
        if (ack_rise) state_next = WR_XFER;
      end
      RD_REQ: begin
        sd_rd = 1'b1;
        if (ack_rise) state_next = RD_XFER;
      end
      WR_XFER: begin
        if (ack_fall) begin
          if (track_sec < LAST_SEC) begin
            sec_next   = 1'b1;
            state_next = WR_REQ;
          end else begin
            wr_done    = 1'b1;
            state_next = RD_REQ;
          end
        end
      end
      RD_XFER: begin
        if (ack_fall) begin
          if (track_sec < LAST_SEC) begin
            sec_next   = 1'b1;
            state_next = RD_REQ;
          end else begin
            rd_done    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A mount always wins over the FSM's own updates so a fresh image forces a reload.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_ack     <= 1'b0;
      mounted     <= 1'b0;
      protect     <= 1'b0;
      reload_pend <= 1'b0;
      dirty       <= 1'b0;
      cur_track   <= '0;
      tgt         <= '0;
      lba_base    <= '0;
      track_sec   <= '0;
    end else begin
      old_ack <= sd_ack;

      if (img_mounted) begin
        mounted <= img_size_nz;
        protect <= img_readonly;
      end

      if (img_mounted)               reload_pend <= 1'b1;
      else if (start_wr || start_rd) reload_pend <= 1'b0;

      // Reading over a dirty buffer (protected image or new mount) discards the edits.
      if (img_mounted)                                 dirty <= 1'b0;
      else if (start_rd || wr_done)                    dirty <= 1'b0;
      else if (state == IDLE && mounted && disk_we)    dirty <= 1'b1;

      if (start_wr || start_rd) tgt <= track;

      if (start_wr)      lba_base <= lba_of(cur_track);
      else if (start_rd) lba_base <= lba_of(track);
      else if (wr_done)  lba_base <= lba_of(tgt);

      if (start_wr || start_rd || wr_done || rd_done) track_sec <= '0;
      else if (sec_next)                              track_sec <= track_sec + 4'd1;

      if (rd_done)                       cur_track <= tgt;
      else if (state == IDLE && !mounted) cur_track <= track;
    end
  end

endmodule

// File: tb/tb_fdd_track_cache_ctrl.sv
// Scoreboard bench for fdd_track_cache_ctrl: a track-level model queues expected
// block requests, a monitor checks each request the DUT issues, a responder acks them.
module tb_fdd_track_cache_ctrl;

  localparam int SECTORS    = 13;
  localparam int TRACK_BITS = 6;
  localparam int BOUND      = 3000;

  logic                  clk_sys;
  logic                  reset;
  logic [TRACK_BITS-1:0] track;
  logic                  disk_we, img_mounted, img_readonly, img_size_nz, sd_ack;
  logic [31:0]           sd_lba;
  logic                  sd_rd, sd_wr, cpu_wait, dirty;
  logic [3:0]            track_sec;

  fdd_track_cache_ctrl #(.SECTORS(SECTORS), .TRACK_BITS(TRACK_BITS)) dut (
    .clk_sys(clk_sys), .reset(reset), .track(track), .disk_we(disk_we),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size_nz(img_size_nz),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .track_sec(track_sec), .cpu_wait(cpu_wait), .dirty(dirty)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
    logic [3:0]  sec;
  } req_t;

  req_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Track-level model of the drive/image state.
  bit m_mounted, m_protect, m_dirty;
  int m_cur;
  logic mon_prev;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_track(input bit wr, input int t);
    req_t e;
    for (int s = 0; s < SECTORS; s++) begin
      e.wr  = wr;
      e.lba = 32'(t * SECTORS + s);
      e.sec = 4'(s);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_move(input int t);
    if (!m_mounted) m_cur = t;
    else if (t != m_cur) begin
      if (m_dirty && !m_protect) push_track(1'b1, m_cur);
      push_track(1'b0, t);
      m_dirty = 1'b0;
      m_cur   = t;
    end
  endtask

  task automatic apply_move(input int t);
    @(posedge clk_sys); #1;
    track = TRACK_BITS'(t);
    model_move(t);
  endtask

  task automatic apply_we();
    @(posedge clk_sys); #1 disk_we = 1'b1;
    @(posedge clk_sys); #1 disk_we = 1'b0;
    if (m_mounted) m_dirty = 1'b1;
  endtask

  task automatic apply_mount(input bit ro, input bit nz);
    @(posedge clk_sys); #1;
    img_mounted  = 1'b1;
    img_readonly = ro;
    img_size_nz  = nz;
    @(posedge clk_sys); #1 img_mounted = 1'b0;
    m_mounted = nz;
    m_protect = ro;
    m_dirty   = 1'b0;
    if (nz) push_track(1'b0, m_cur);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk_sys);
    while ((exp_q.size() != 0 || cpu_wait) && n < BOUND) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= BOUND) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: pending=%0d cpu_wait=%0b", name, exp_q.size(), cpu_wait);
    end
    repeat (4) @(negedge clk_sys);
    check_output({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check_output({name, "_cpu_wait"}, 64'(cpu_wait), 64'd0);
    check_output({name, "_dirty"}, 64'(dirty), 64'(m_dirty));
  endtask

  // Waits for a given block to be in flight: either requested, or acknowledged.
  task automatic wait_lba(input string name, input logic [31:0] lba, input bit on_ack);
    int n = 0;
    @(negedge clk_sys);
    while (!(sd_lba == lba && cpu_wait && (on_ack ? sd_ack : (sd_rd || sd_wr))) && n < BOUND) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= BOUND) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: lba %0d never seen", name, lba);
    end
  endtask

  // SD host model: acknowledges each request after a random delay for a random length.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if ((sd_rd || sd_wr) && !reset) begin
        repeat ($urandom_range(0, 3)) @(posedge clk_sys);
        @(posedge clk_sys); #1 sd_ack = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk_sys);
        #1 sd_ack = 1'b0;
      end
    end
  end

  // Monitor: every newly presented request must match the head of the scoreboard.
  initial begin
    req_t e;
    mon_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) mon_prev = 1'b0;
      else begin
        if ((sd_rd || sd_wr) && !mon_prev) begin
          check_output("rd_wr_exclusive", 64'(sd_rd & sd_wr), 64'd0);
          check_output("cpu_wait_on_req", 64'(cpu_wait), 64'd1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_req: wr=%0b lba=%0d sec=%0d, none expected",
                     sd_wr, sd_lba, track_sec);
          end else begin
            e = exp_q.pop_front();
            check_output("req_wr_lba_sec", 64'({sd_wr, sd_lba, track_sec}), 64'(e));
          end
        end
        mon_prev = sd_rd || sd_wr;
      end
    end
  end

  initial begin
    int n;
    int t;
    reset        = 1'b0;
    track        = '0;
    disk_we      = 1'b0;
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    img_size_nz  = 1'b0;
    m_mounted = 0; m_protect = 0; m_dirty = 0; m_cur = 0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    check_output("rst_lba", 64'(sd_lba), 64'd0);
    check_output("rst_rd_wr", 64'({sd_rd, sd_wr}), 64'd0);
    check_output("rst_sec", 64'(track_sec), 64'd0);
    check_output("rst_wait_dirty", 64'({cpu_wait, dirty}), 64'd0);
    @(posedge clk_sys); #1 reset = 1'b0;

    // Mount loads track 0, then plain seek to 5.
    apply_mount(1'b0, 1'b1);
    wait_idle("mount_t0");
    apply_move(5);
    wait_idle("seek_5");

    // Dirty track 5, seek to 17: write-back then read; dirty gone before first read.
    apply_we();
    @(negedge clk_sys);
    check_output("dirty_set", 64'(dirty), 64'd1);
    apply_move(17);
    wait_lba("wb_first_read", 32'(17 * SECTORS), 1'b0);
    check_output("dirty_after_wb", 64'(dirty), 64'd0);
    wait_idle("seek_17_wb");

    // Read-only image: dirty edits are discarded, no write-back.
    apply_mount(1'b1, 1'b1);
    wait_idle("mount_ro");
    apply_move(5);
    wait_idle("ro_seek_5");
    apply_we();
    apply_move(17);
    wait_idle("ro_seek_17");

    // Track change mid-operation: current track completes, one idle cycle, then next.
    apply_mount(1'b0, 1'b1);
    wait_idle("remount");
    apply_move(5);
    wait_lba("mid_67", 32'd67, 1'b1);
    apply_move(6);
    n = 0;
    @(negedge clk_sys);
    while (cpu_wait && n < BOUND) begin
      @(negedge clk_sys);
      n++;
    end
    @(negedge clk_sys);
    check_output("wait_gap_one_cycle", 64'(cpu_wait), 64'd1);
    wait_idle("seek_6_mid");

    // Randomized mix of seeks, writes (idle and busy) and mounts.
    repeat (30) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          t = int'($urandom_range(0, 63));
          apply_move(t);
          if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
            n = 0;
            @(negedge clk_sys);
            while (!cpu_wait && n < 10) begin
              @(negedge clk_sys);
              n++;
            end
            @(posedge clk_sys); #1 disk_we = 1'b1;
            @(posedge clk_sys); #1 disk_we = 1'b0;
          end
        end
        5, 6, 7: apply_we();
        default: apply_mount(1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
      endcase
      wait_idle("rand");
    end

    // Reset during a read aborts everything and leaves the drive unmounted.
    apply_move(0);
    wait_idle("pre_rst_home");
    apply_mount(1'b0, 1'b1);
    wait_idle("pre_rst_mount");
    apply_move(5);
    wait_lba("rst_at_70", 32'd70, 1'b1);
    @(posedge clk_sys); #1 reset = 1'b1;
    @(negedge clk_sys);
    check_output("abort_rd_wr", 64'({sd_rd, sd_wr}), 64'd0);
    check_output("abort_wait", 64'(cpu_wait), 64'd0);
    check_output("abort_sec", 64'(track_sec), 64'd0);
    check_output("abort_dirty", 64'(dirty), 64'd0);
    exp_q.delete();
    m_mounted = 0; m_protect = 0; m_dirty = 0; m_cur = 5;
    @(posedge clk_sys); #1 reset = 1'b0;
    apply_move(9);
    wait_idle("unmounted_9");
    apply_we();
    apply_move(20);
    wait_idle("unmounted_20");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fdd_track_cache_ctrl.md
Name: fdd_track_cache_ctrl

Overview:
- Sits between apple2_top's floppy track-buffer interface and hps_io's sd_* block-request port (virtual disk 0).
- Loads a whole track of SECTORS 512-byte blocks into the track buffer whenever the drive's head track changes or an image is mounted.
- Writes a modified track back to the image before replacing it.
- Stalls the CPU for the whole transfer.

Parameters:
- SECTORS, 13, 512-byte blocks per track image (NIB track = 6656 bytes).
- TRACK_BITS, 6, width of track number.

Ports:
- clk_sys  in  1  system clock (14.318 MHz).
- reset  in  1  asynchronous, active-high reset.
- track  in  TRACK_BITS  current head track from drive emulation.
- disk_we  in  1  drive-side write strobe into the track buffer; marks the track dirty.
- img_mounted  in  1  one-cycle pulse: a new image was mounted on disk 0.
- img_readonly  in  1  the mounted image is read-only; sampled on img_mounted.
- img_size_nz  in  1  mounted image size is non-zero; sampled on img_mounted.
- sd_ack  in  1  hps_io acknowledge; high while the block is being transferred.
- sd_lba  out  32  block address of the current request.
- sd_rd  out  1  block read request.
- sd_wr  out  1  block write request.
- track_sec  out  4  sector index within track; upper bits of the track-buffer address.
- cpu_wait  out  1  CPU stall request.
- dirty  out  1  the buffer holds unsaved modifications.

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, track_sec=0, cpu_wait=0, dirty=0. Internally: mounted=0, protect=0, cur_track=0, state=IDLE.
- Reset mid-transfer aborts immediately. Requests drop and the dirty data is lost. No completion of the partial block is attempted.
- An old_ack register samples sd_ack every cycle.
  - ack_rise = sd_ack & ~old_ack.
  - ack_fall = ~sd_ack & old_ack.
- img_mounted, in any state:
  - latch mounted<=img_size_nz and protect<=img_readonly.
  - clear dirty.
  - set reload_pend.
  - If an operation is in progress, it continues to completion, then reload_pend triggers a fresh read.
- disk_we sets dirty only when state==IDLE and mounted. It is ignored while busy, because the CPU is stalled and any strobe then is spurious.
- States: IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER.
- IDLE: leave only when mounted and the start condition holds. Start condition: (track != cur_track) or reload_pend.
  - Capture tgt<=track and clear reload_pend.
  - Set track_sec=0 and cpu_wait=1.
  - If dirty & ~protect & ~reload_pend: go to WR_REQ, with lba base = SECTORS*cur_track.
  - Otherwise: go to RD_REQ, with lba base = SECTORS*track.
  - If not mounted: cur_track<=track silently, and no request is issued.
- WR_REQ / RD_REQ: sd_lba = base + track_sec, and sd_wr or sd_rd is held at 1. On ack_rise, drop the request and go to the matching XFER state.
- WR_XFER / RD_XFER: on ack_fall:
  - If track_sec < SECTORS-1: track_sec+1 and return to the REQ state.
  - Else, from WR_XFER: clear dirty, track_sec=0, go to RD_REQ with base = SECTORS*tgt.
  - Else, from RD_XFER: cur_track<=tgt, track_sec=0, cpu_wait=0, go to IDLE.
- Arithmetic: lba = SECTORS*track computed in 32 bits, zero-extended. track_sec is 4 bits, so SECTORS must be ≤16.
- Dirty on a protected image: the write-back is skipped, dirty is cleared, and the read proceeds.
- If track changes during an operation, tgt is unaffected. On return to IDLE, a new mismatch starts another operation on the next cycle.
- sd_rd and sd_wr are never high together. At most one request is outstanding.
- cpu_wait is high from the first request cycle through the ack_fall of the final read block.

Test Plan:
- Mount with img_size_nz=1, track=0 → 13 reads, lba 0..12, track_sec 0..12. cpu_wait goes high, then low after the 13th ack_fall.
- Track 0→5 with no disk_we → reads lba 65..77 only. sd_wr never asserted.
- On track 5, pulse disk_we, then move to track 17 → writes lba 65..77, then reads lba 221..233. dirty clears after write lba 77.
- Same as the previous case with img_readonly=1 at mount → no sd_wr. Reads lba 221..233. dirty=0 at the end.
- Assert reset during the read of lba 70 (sd_ack high) → next cycle sd_rd=0, cpu_wait=0, track_sec=0, dirty=0. No further requests until a mount.
- Track changes 5→6 during the read of lba 67 → lba 65..77 completes, cpu_wait drops for one cycle, then reads lba 78..90.
